// File: rtl/rob.sv
// Reorder buffer: in-order allocation from the decoder, out-of-order completion
// from the RS with a one-cycle wake-up broadcast, in-order retirement and
// flush/redirect on taken control flow.
module rob #(
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 rdy_in,
  input  logic                 from_decoder,
  input  logic [1:0]           from_decoder_op,
  input  logic [4:0]           from_decoder_rd,
  output logic                 to_decoder,
  output logic [ROB_WIDTH-1:0] to_decoder_tag,
  input  logic                 from_rs,
  input  logic [ROB_WIDTH-1:0] from_rs_tag,
  input  logic [31:0]          from_rs_wdata,
  input  logic [31:0]          from_rs_jump,
  input  logic                 from_rs_taken,
  output logic                 to_rs_update,
  output logic [ROB_WIDTH-1:0] to_rs_update_order,
  output logic [31:0]          to_rs_update_wdata,
  output logic                 to_reg_file,
  output logic [4:0]           to_reg_file_rd,
  output logic [31:0]          to_reg_file_wdata,
  output logic                 clear,
  output logic [31:0]          to_fetch_pc
);
  localparam int DEPTH = 1 << ROB_WIDTH;
  localparam logic [ROB_WIDTH-1:0] PTR_ONE = 1;
  localparam logic [ROB_WIDTH:0]   CNT_ONE = 1;

  typedef struct packed {
    logic        busy;
    logic        ready;
    logic [1:0]  op;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic [31:0] jump;
    logic        taken;
  } ent_t;

  ent_t                 ent_q [DEPTH];
  logic [ROB_WIDTH-1:0] head_q, tail_q;
  logic [ROB_WIDTH:0]   count_q, count_d;
  logic                 dec_q;
  logic                 upd_q, rf_we_q, clear_q;
  logic [ROB_WIDTH-1:0] upd_tag_q;
  logic [31:0]          upd_wd_q, rf_wd_q, pc_q;
  logic [4:0]           rf_rd_q;

  ent_t hd, cp;
  logic do_alloc, do_comp, do_commit, redirect, wr_reg;

  assign hd = ent_q[head_q];
  assign cp = ent_q[from_rs_tag];

  // The MSB of count is set only when all DEPTH entries are live.
  assign do_alloc  = from_decoder && !count_q[ROB_WIDTH] && !clear_q;
  assign do_comp   = from_rs && cp.busy && !cp.ready && !clear_q;
  assign do_commit = hd.busy && hd.ready && !clear_q;
  assign redirect  = do_commit && (hd.op == 2'b10 || (hd.op == 2'b01 && hd.taken));
  assign wr_reg    = do_commit && (hd.op == 2'b00 || hd.op == 2'b10) && (hd.rd != '0);

  always_comb begin
    count_d = count_q;
    if (clear_q) count_d = '0;
    else begin
      case ({do_alloc, do_commit})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      dec_q     <= 1'b1;
      upd_q     <= 1'b0;
      upd_tag_q <= '0;
      upd_wd_q  <= '0;
      rf_we_q   <= 1'b0;
      rf_rd_q   <= '0;
      rf_wd_q   <= '0;
      clear_q   <= 1'b0;
      pc_q      <= '0;
    end else if (rdy_in) begin
      count_q <= count_d;
      dec_q   <= !count_d[ROB_WIDTH];
      // Results completing alongside a flush belong to squashed entries.
      upd_q   <= do_comp && !redirect;
      rf_we_q <= wr_reg;
      clear_q <= redirect;
      if (do_comp) begin
        upd_tag_q <= from_rs_tag;
        upd_wd_q  <= from_rs_wdata;
      end
      if (wr_reg) begin
        rf_rd_q <= hd.rd;
        rf_wd_q <= hd.wdata;
      end
      if (redirect) pc_q <= hd.jump;
      if (clear_q) begin
        head_q <= '0;
        tail_q <= '0;
        for (int i = 0; i < DEPTH; i++) ent_q[i].busy <= 1'b0;
      end else begin
        if (do_alloc) begin
          ent_q[tail_q].busy  <= 1'b1;
          ent_q[tail_q].ready <= 1'b0;
          ent_q[tail_q].op    <= from_decoder_op;
          ent_q[tail_q].rd    <= from_decoder_rd;
          tail_q              <= tail_q + PTR_ONE;
        end
        if (do_comp) begin
          ent_q[from_rs_tag].ready <= 1'b1;
          ent_q[from_rs_tag].wdata <= from_rs_wdata;
          ent_q[from_rs_tag].jump  <= from_rs_jump;
          ent_q[from_rs_tag].taken <= from_rs_taken;
        end
        if (do_commit) begin
          ent_q[head_q].busy <= 1'b0;
          head_q             <= head_q + PTR_ONE;
        end
      end
    end
  end

  assign to_decoder         = dec_q;
  assign to_decoder_tag     = tail_q;
  assign to_rs_update       = upd_q & rdy_in;
  assign to_rs_update_order = upd_tag_q;
  assign to_rs_update_wdata = upd_wd_q;
  assign to_reg_file        = rf_we_q & rdy_in;
  assign to_reg_file_rd     = rf_rd_q;
  assign to_reg_file_wdata  = rf_wd_q;
  assign clear              = clear_q & rdy_in;
  assign to_fetch_pc        = pc_q;
endmodule

// File: tb/tb_rob.sv
// Bench for rob: a queue-based program-order model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_rob;
  localparam int DEPTH = 16;

  logic        clk_in = 1'b0, rst_n_in = 1'b0, rdy_in = 1'b1;
  logic        from_decoder = 1'b0;
  logic [1:0]  from_decoder_op = '0;
  logic [4:0]  from_decoder_rd = '0;
  logic        to_decoder;
  logic [3:0]  to_decoder_tag;
  logic        from_rs = 1'b0;
  logic [3:0]  from_rs_tag = '0;
  logic [31:0] from_rs_wdata = '0, from_rs_jump = '0;
  logic        from_rs_taken = 1'b0;
  logic        to_rs_update;
  logic [3:0]  to_rs_update_order;
  logic [31:0] to_rs_update_wdata;
  logic        to_reg_file;
  logic [4:0]  to_reg_file_rd;
  logic [31:0] to_reg_file_wdata;
  logic        clear;
  logic [31:0] to_fetch_pc;

  rob #(.ROB_WIDTH(4)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .from_decoder(from_decoder), .from_decoder_op(from_decoder_op),
    .from_decoder_rd(from_decoder_rd), .to_decoder(to_decoder),
    .to_decoder_tag(to_decoder_tag), .from_rs(from_rs), .from_rs_tag(from_rs_tag),
    .from_rs_wdata(from_rs_wdata), .from_rs_jump(from_rs_jump),
    .from_rs_taken(from_rs_taken), .to_rs_update(to_rs_update),
    .to_rs_update_order(to_rs_update_order), .to_rs_update_wdata(to_rs_update_wdata),
    .to_reg_file(to_reg_file), .to_reg_file_rd(to_reg_file_rd),
    .to_reg_file_wdata(to_reg_file_wdata), .clear(clear), .to_fetch_pc(to_fetch_pc)
  );

  always #5 clk_in = ~clk_in;

  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Program-order model: the queue holds live instructions oldest first; a
  // tag is the allocation ordinal since the last flush, modulo DEPTH.
  typedef struct {
    int         tag;
    logic [1:0] op;
    logic [4:0] rd;
    bit         ready;
    logic [31:0] wdata, jump;
    bit         taken;
  } m_ent_t;

  m_ent_t      mq[$];
  int          m_alloc_cnt = 0;
  bit          m_dec = 1'b1, m_upd = 1'b0, m_rf = 1'b0, m_clr = 1'b0;
  int          m_upd_tag = 0;
  logic [31:0] m_upd_wd = '0, m_rf_wd = '0, m_pc = '0;
  logic [4:0]  m_rf_rd = '0;

  function automatic void model_reset();
    mq.delete();
    m_alloc_cnt = 0;
    m_dec = 1'b1; m_upd = 1'b0; m_rf = 1'b0; m_clr = 1'b0; m_pc = '0;
  endfunction

  function automatic void model_step();
    int     n0, hit;
    bit     commit, redir;
    m_ent_t e, a;
    if (m_clr) begin
      model_reset();
      return;
    end
    n0 = mq.size();
    hit = -1;
    redir = 1'b0;
    m_upd = 1'b0;
    m_rf = 1'b0;
    commit = (n0 > 0) && mq[0].ready;
    if (commit) begin
      e = mq[0];
      if ((e.op == 2'b00 || e.op == 2'b10) && e.rd != 0) begin
        m_rf = 1'b1; m_rf_rd = e.rd; m_rf_wd = e.wdata;
      end
      if (e.op == 2'b10 || (e.op == 2'b01 && e.taken)) begin
        redir = 1'b1; m_clr = 1'b1; m_pc = e.jump;
      end
    end
    if (from_rs)
      for (int i = 0; i < n0; i++)
        if (mq[i].tag == int'(from_rs_tag) && !mq[i].ready) hit = i;
    if (hit >= 0) begin
      mq[hit].ready = 1'b1;
      mq[hit].wdata = from_rs_wdata;
      mq[hit].jump  = from_rs_jump;
      mq[hit].taken = from_rs_taken;
      if (!redir) begin
        m_upd = 1'b1; m_upd_tag = int'(from_rs_tag); m_upd_wd = from_rs_wdata;
      end
    end
    if (commit) void'(mq.pop_front());
    if (from_decoder && n0 < DEPTH) begin
      a.tag = m_alloc_cnt % DEPTH; a.op = from_decoder_op; a.rd = from_decoder_rd;
      a.ready = 1'b0; a.wdata = '0; a.jump = '0; a.taken = 1'b0;
      mq.push_back(a);
      m_alloc_cnt++;
    end
    m_dec = mq.size() < DEPTH;
  endfunction

  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) model_reset();
    else if (rdy_in) model_step();
  end

  always @(negedge clk_in) begin
    chk("to_decoder", 32'(to_decoder), 32'(m_dec));
    chk("to_decoder_tag", 32'(to_decoder_tag), m_alloc_cnt % DEPTH);
    chk("to_rs_update", 32'(to_rs_update), 32'(m_upd & rdy_in));
    if (m_upd && rdy_in) begin
      chk("upd_order", 32'(to_rs_update_order), m_upd_tag);
      chk("upd_wdata", to_rs_update_wdata, m_upd_wd);
    end
    chk("to_reg_file", 32'(to_reg_file), 32'(m_rf & rdy_in));
    if (m_rf && rdy_in) begin
      chk("rf_rd", 32'(to_reg_file_rd), 32'(m_rf_rd));
      chk("rf_wdata", to_reg_file_wdata, m_rf_wd);
    end
    chk("clear", 32'(clear), 32'(m_clr & rdy_in));
    if (m_clr && rdy_in) chk("fetch_pc", to_fetch_pc, m_pc);
  end

  task automatic cyc();
    @(posedge clk_in); #1;
    from_decoder = 1'b0;
    from_rs = 1'b0;
  endtask

  task automatic alloc(input logic [1:0] op, input logic [4:0] rd);
    from_decoder = 1'b1; from_decoder_op = op; from_decoder_rd = rd;
    cyc();
  endtask

  task automatic comp(input logic [3:0] tag, input logic [31:0] wd,
                      input logic [31:0] jp, input logic tk);
    from_rs = 1'b1; from_rs_tag = tag; from_rs_wdata = wd;
    from_rs_jump = jp; from_rs_taken = tk;
    cyc();
  endtask

  initial begin
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_dec", 32'(to_decoder), 1);
    chk("rst_upd", 32'(to_rs_update), 0);
    chk("rst_rf", 32'(to_reg_file), 0);
    chk("rst_clear", 32'(clear), 0);
    chk("rst_pc", to_fetch_pc, 0);
    rst_n_in = 1'b1;

    // in-order commit of out-of-order completions
    chk("tag0", 32'(to_decoder_tag), 0); alloc(2'b00, 5'd5);
    chk("tag1", 32'(to_decoder_tag), 1); alloc(2'b00, 5'd6);
    chk("tag2", 32'(to_decoder_tag), 2); alloc(2'b00, 5'd7);
    comp(4'd1, 32'h22, 0, 1'b0);
    chk("bc1_v", 32'(to_rs_update), 1);
    chk("bc1_ord", 32'(to_rs_update_order), 1);
    chk("bc1_wd", to_rs_update_wdata, 32'h22);
    chk("no_early_commit", 32'(to_reg_file), 0);
    comp(4'd0, 32'h11, 0, 1'b0);
    chk("bc0_ord", 32'(to_rs_update_order), 0);
    cyc();
    chk("c5_we", 32'(to_reg_file), 1);
    chk("c5_rd", 32'(to_reg_file_rd), 5);
    chk("c5_wd", to_reg_file_wdata, 32'h11);
    cyc();
    chk("c6_rd", 32'(to_reg_file_rd), 6);
    chk("c6_wd", to_reg_file_wdata, 32'h22);
    comp(4'd2, 32'h33, 0, 1'b0);
    cyc();
    cyc();

    // branches: not taken, then taken
    alloc(2'b01, 5'd0);
    comp(4'd3, 32'h0, 32'h500, 1'b0);
    cyc();
    chk("nt_clear", 32'(clear), 0);
    chk("nt_rf", 32'(to_reg_file), 0);
    alloc(2'b01, 5'd0);
    comp(4'd4, 32'h0, 32'h1000, 1'b1);
    cyc();
    chk("tk_clear", 32'(clear), 1);
    chk("tk_pc", to_fetch_pc, 32'h1000);
    cyc();
    chk("tk_clear_off", 32'(clear), 0);
    chk("tk_dec", 32'(to_decoder), 1);
    chk("tk_tag", 32'(to_decoder_tag), 0);

    // JAL with younger entries behind it
    alloc(2'b10, 5'd1);
    alloc(2'b00, 5'd9);
    alloc(2'b00, 5'd10);
    comp(4'd1, 32'h99, 0, 1'b0);
    comp(4'd0, 32'h8, 32'h40, 1'b0);
    cyc();
    chk("jal_we", 32'(to_reg_file), 1);
    chk("jal_rd", 32'(to_reg_file_rd), 1);
    chk("jal_wd", to_reg_file_wdata, 32'h8);
    chk("jal_clear", 32'(clear), 1);
    chk("jal_pc", to_fetch_pc, 32'h40);
    from_decoder = 1'b1; from_decoder_op = 2'b00; from_decoder_rd = 5'd3;
    from_rs = 1'b1; from_rs_tag = 4'd2; from_rs_wdata = 32'hEE;
    from_rs_jump = 0; from_rs_taken = 1'b0;
    cyc();
    chk("flush_upd", 32'(to_rs_update), 0);
    chk("flush_tag", 32'(to_decoder_tag), 0);
    chk("flush_rf", 32'(to_reg_file), 0);
    cyc();
    chk("flush_discard", 32'(to_reg_file), 0);

    // fill to capacity, refuse, wrap
    for (int i = 0; i < DEPTH; i++) alloc(2'b00, 5'(i + 1));
    chk("full_dec", 32'(to_decoder), 0);
    chk("full_tag", 32'(to_decoder_tag), 0);
    alloc(2'b00, 5'd20);
    chk("full_refused", 32'(to_decoder), 0);
    comp(4'd0, 32'hA0, 0, 1'b0);
    cyc();
    chk("wrap_dec", 32'(to_decoder), 1);
    chk("wrap_rf_wd", to_reg_file_wdata, 32'hA0);
    chk("wrap_tag", 32'(to_decoder_tag), 0);
    alloc(2'b00, 5'd21);
    chk("refull_dec", 32'(to_decoder), 0);
    for (int t = 1; t <= 11; t++) comp(4'(t), 32'h100 + t, 0, 1'b0);
    cyc();
    chk("pre_rst_rf", 32'(to_reg_file), 1);
    chk("pre_rst_rd", 32'(to_reg_file_rd), 12);

    // async reset with 5 live entries
    rst_n_in = 1'b0;
    #1;
    chk("arst_dec", 32'(to_decoder), 1);
    chk("arst_tag", 32'(to_decoder_tag), 0);
    chk("arst_rf", 32'(to_reg_file), 0);
    chk("arst_upd", 32'(to_rs_update), 0);
    chk("arst_pc", to_fetch_pc, 0);
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;

    // rd=0 and duplicate completions
    alloc(2'b00, 5'd0);
    comp(4'd0, 32'h77, 0, 1'b0);
    chk("rd0_bc", 32'(to_rs_update), 1);
    chk("rd0_bc_wd", to_rs_update_wdata, 32'h77);
    comp(4'd0, 32'h55, 0, 1'b0);
    chk("dup_no_bc", 32'(to_rs_update), 0);
    chk("rd0_no_write", 32'(to_reg_file), 0);
    comp(4'd0, 32'h66, 0, 1'b0);
    chk("stale_no_bc", 32'(to_rs_update), 0);

    // freeze with activity on the inputs
    alloc(2'b00, 5'd12);
    rdy_in = 1'b0;
    from_rs = 1'b1; from_rs_tag = 4'd1; from_rs_wdata = 32'hAB;
    from_decoder = 1'b1; from_decoder_op = 2'b00; from_decoder_rd = 5'd13;
    repeat (3) begin
      @(posedge clk_in); #1;
      chk("frz_upd", 32'(to_rs_update), 0);
      chk("frz_tag", 32'(to_decoder_tag), 2);
    end
    rdy_in = 1'b1;
    from_rs = 1'b0; from_decoder = 1'b0;
    cyc();
    chk("thaw_upd", 32'(to_rs_update), 0);
    chk("thaw_rf", 32'(to_reg_file), 0);
    comp(4'd1, 32'hCD, 0, 1'b0);
    chk("thaw_bc_wd", to_rs_update_wdata, 32'hCD);
    cyc();
    chk("thaw_rf_rd", 32'(to_reg_file_rd), 12);
    chk("thaw_rf_wd", to_reg_file_wdata, 32'hCD);
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rob.md
Name: rob

Overview:
Reorder buffer. It is the receiving end of the reservation station's completion interface (to_rob_*) and the driver of its from_rob_update broadcast.
- Allocates entries in program order from the decoder.
- Collects out-of-order ALU completions from the RS and broadcasts each result back to the RS for operand wake-up.
- Retires entries in order to the register file.
- Raises clear plus a redirect PC on a taken branch or jump.

Parameters:
ROB_WIDTH, 4, tag/index width; depth DEPTH = 2**ROB_WIDTH (16 entries)

Ports:
clk_in  input  1  clock, rising edge
rst_n_in  input  1  asynchronous active-low reset
rdy_in  input  1  global enable; when low, all state holds
from_decoder  input  1  allocate request
from_decoder_op  input  2  00 write reg, 01 branch, 10 jump (write reg + redirect)
from_decoder_rd  input  5  destination register
to_decoder  output  1  registered; 1 = an entry is free next cycle
to_decoder_tag  output  ROB_WIDTH  combinational; tag granted (= tail)
from_rs  input  1  completion valid
from_rs_tag  input  ROB_WIDTH  completing entry
from_rs_wdata  input  32  register result
from_rs_jump  input  32  branch/jump target
from_rs_taken  input  1  branch outcome (ignored for op 00; op 10 always treated as taken)
to_rs_update  output  1  result broadcast valid
to_rs_update_order  output  ROB_WIDTH  tag being broadcast
to_rs_update_wdata  output  32  broadcast value
to_reg_file  output  1  register write enable
to_reg_file_rd  output  5  write address
to_reg_file_wdata  output  32  write data
clear  output  1  flush pulse to decoder/RS/fetch
to_fetch_pc  output  32  redirect target, valid while clear=1

Behaviour:
Storage and reset:
- Circular buffer: head, tail (ROB_WIDTH bits, wrap naturally) and count (ROB_WIDTH+1 bits).
- Per entry: busy, ready, op, rd, wdata, jump, taken.
- Reset (async, rst_n_in=0): head=tail=count=0, all busy=0, to_decoder=1, every other output 0.

Allocation:
- Occurs on from_decoder && count<DEPTH && !clear.
- Entry[tail] gets busy=1, ready=0, op, rd; tail+1.
- The granted tag is to_decoder_tag sampled in the same cycle.
- Request while full: ignored, no state change.

Completion:
- Occurs on from_rs with busy[from_rs_tag]=1 and ready=0.
- Stores wdata, jump, taken and sets ready=1.
- Next cycle: to_rs_update=1, to_rs_update_order=from_rs_tag, to_rs_update_wdata=from_rs_wdata, each for exactly one cycle (1-cycle latency).
- Completion to a non-busy or already-ready entry: dropped, no broadcast.

Commit (one per cycle):
- Condition: busy[head] && ready[head].
- busy[head]=0, head+1.
- If op is 00 or 10 and rd!=0: next cycle to_reg_file=1 with rd and wdata for one cycle. rd=0 gives no write.
- A value may be committed in the cycle after its completion at the earliest (ready is registered).

Redirect:
- Committing op 01 with taken=1, or any op 10, sets clear=1 and to_fetch_pc=jump next cycle; the register write of op 10 is still issued in that same cycle.
- During the cycle clear=1: all entries' busy=0, head=tail=count=0. Allocation, completion and commit are all ignored, and no to_rs_update is produced.
- clear lasts exactly one cycle.

Count and to_decoder:
- Alloc and commit in the same cycle leave count unchanged. Alloc into a full buffer with a simultaneous commit is still refused, because the full check uses current count.
- to_decoder is registered as (next count < DEPTH).

Other rules:
- An entry completing at the same time it is committed cannot occur (commit requires ready).
- Completion to the head entry in the same cycle as a commit of a different entry is legal.
- rdy_in=0 freezes all state. Single-cycle pulse outputs (to_rs_update, to_reg_file, clear) are forced to 0 while frozen.
- Reset mid-operation discards all entries immediately, asynchronously.

Test Plan:
- Reset, then 3 allocs (op 00, rd=5,6,7) -> tags 0,1,2.
  - Complete tag 1 (wdata=0x22) -> to_rs_update order=1, wdata=0x22 next cycle; no commit.
  - Complete tag 0 (0x11) -> commits rd5=0x11, then rd6=0x22 on consecutive cycles.
- Fill 16 entries -> to_decoder=0.
  - 17th alloc ignored.
  - Commit head -> to_decoder=1; wrapped alloc gets tag 0.
- Alloc branch (op 01) and complete with taken=0 -> no clear.
  - Repeat with taken=1, jump=0x1000 -> clear=1, to_fetch_pc=0x1000 for one cycle; count=0 afterwards.
- JAL (op 10, rd=1, wdata=0x8, jump=0x40) -> reg write x1=0x8 and clear with pc 0x40 in the same cycle.
  - Younger entries allocated before the flush are discarded.
- Completion with rd=0 -> broadcast occurs, no reg-file write.
  - Duplicate completion on same tag -> no second broadcast.
- Assert rst_n_in low mid-stream with 5 entries live -> all outputs 0 and to_decoder=1 immediately.
  - Hold rdy_in=0 for 3 cycles while from_rs is pulsed -> no state change.
